// File: rtl/mem_txn_assembler.sv
// Turns tagged words from an async FIFO into read/write transactions with a ready/valid output.
// Optional saturating protocol-error counter: define MEM_TXN_ASSEMBLER_ERR_CNT_EN.
module mem_txn_assembler #(
  parameter int WIDTH = 34,
  parameter int ERR_W = 8
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic             fifo_empty,
  output logic             fifo_r_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             txn_valid,
  input  logic             txn_ready,
  output logic             txn_we,
  output logic [31:0]      txn_addr,
  output logic [31:0]      txn_wdata,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, OUT} state_t;

  localparam logic [1:0] TAG_RSV = 2'b00;
  localparam logic [1:0] TAG_RD  = 2'b01;
  localparam logic [1:0] TAG_WR  = 2'b10;
  localparam logic [1:0] TAG_DAT = 2'b11;

  state_t             state_q, state_d, eff_state;
  logic [WIDTH-1:0]   q_q [2];
  logic [WIDTH-1:0]   q_d [2];
  logic [1:0]         cnt_q, cnt_d;
  logic               inflight_q;
  logic               valid_q, valid_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic [WIDTH-1:0]   head;
  logic [1:0]         head_tag;
  logic               head_valid;
  logic               take;
  logic               from_queue;
  logic               to_queue;
  logic [2:0]         occ;

  // With an empty queue the word arriving from the FIFO is used directly,
  // which is what gives the two-cycle pop-to-valid latency.
  assign head       = (cnt_q != 2'd0) ? q_q[0] : fifo_data;
  assign head_tag   = head[WIDTH-1 -: 2];
  assign head_valid = (cnt_q != 2'd0) || inflight_q;
  assign take       = head_valid && ((state_q != OUT) || txn_ready);
  assign from_queue = take && (cnt_q != 2'd0);
  assign to_queue   = inflight_q && !(take && (cnt_q == 2'd0));
  assign eff_state  = (state_q == OUT) ? IDLE : state_q;

  assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, take};
  assign fifo_r_en = !r_rst && !fifo_empty && (occ < 3'd2);

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (from_queue) begin
      q_d[0] = q_q[1];
      cnt_d  = cnt_q - 2'd1;
    end
    if (to_queue) begin
      q_d[cnt_d[0]] = fifo_data;
      cnt_d         = cnt_d + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if ((state_q == OUT) && txn_ready) begin
      state_d = IDLE;
    end
    if (take) begin
      case (head_tag)
        TAG_RD: begin
          addr_d  = head[31:0];
          we_d    = 1'b0;
          wdata_d = 32'd0;
          state_d = OUT;
        end
        TAG_WR: begin
          addr_d  = head[31:0];
          state_d = WAIT_DATA;
        end
        TAG_DAT: begin
          if (eff_state == WAIT_DATA) begin
            wdata_d = head[31:0];
            we_d    = 1'b1;
            state_d = OUT;
          end else begin
            state_d = eff_state;
          end
        end
        default: state_d = eff_state;
      endcase
    end
    valid_d = (state_d == OUT);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= fifo_r_en;
      valid_q    <= valid_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_queue
    always_ff @(posedge r_clk) begin
      if (r_rst) begin
        q_q[gi] <= '0;
      end else begin
        q_q[gi] <= q_d[gi];
      end
    end
  end

  assign txn_valid = valid_q;
  assign txn_we    = we_q;
  assign txn_addr  = addr_q;
  assign txn_wdata = wdata_q;

`ifdef MEM_TXN_ASSEMBLER_ERR_CNT_EN
  logic             err_evt;
  logic [ERR_W-1:0] err_q;

  // Stray data, reserved tags, and an address arriving while a write waits for data.
  assign err_evt = take && ((head_tag == TAG_RSV) ||
                            ((head_tag == TAG_DAT) && (eff_state != WAIT_DATA)) ||
                            (((head_tag == TAG_RD) || (head_tag == TAG_WR)) &&
                             (eff_state == WAIT_DATA)));

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      err_q <= '0;
    end else if (err_evt && !(&err_q)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_mem_txn_assembler.sv
// Bench for mem_txn_assembler: FIFO model, word-stream reference parser and txn scoreboard.
module tb_mem_txn_assembler;

  localparam int ERR_W   = 2;
  localparam int ERR_MAX = 3;

  logic        r_clk = 1'b0;
  logic        r_rst;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic [33:0] fifo_data;
  logic        txn_valid;
  logic        txn_ready;
  logic        txn_we;
  logic [31:0] txn_addr;
  logic [31:0] txn_wdata;
  logic [ERR_W-1:0] err_count;

  mem_txn_assembler #(.WIDTH(34), .ERR_W(ERR_W)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
    .fifo_data(fifo_data), .txn_valid(txn_valid), .txn_ready(txn_ready),
    .txn_we(txn_we), .txn_addr(txn_addr), .txn_wdata(txn_wdata), .err_count(err_count)
  );

  always #5 r_clk = ~r_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [33:0] fifo_q[$];
  logic [64:0] exp_q[$];
  int          mdl_err;
  bit          mdl_pend;
  logic [31:0] mdl_addr;
  bit          prev_hold;
  logic [64:0] prev_out;
  bit          last_valid;
  int          pop_cyc, first_valid_cyc, valid_cycles, pops;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: parse the word stream by the tag rules, independent of timing.
  task automatic model_word(input logic [33:0] w);
    case (w[33:32])
      2'b01: begin
        if (mdl_pend) mdl_err = (mdl_err < ERR_MAX) ? mdl_err + 1 : mdl_err;
        mdl_pend = 0;
        exp_q.push_back({1'b0, w[31:0], 32'd0});
      end
      2'b10: begin
        if (mdl_pend) mdl_err = (mdl_err < ERR_MAX) ? mdl_err + 1 : mdl_err;
        mdl_pend = 1;
        mdl_addr = w[31:0];
      end
      2'b11: begin
        if (mdl_pend) exp_q.push_back({1'b1, mdl_addr, w[31:0]});
        else mdl_err = (mdl_err < ERR_MAX) ? mdl_err + 1 : mdl_err;
        mdl_pend = 0;
      end
      default: mdl_err = (mdl_err < ERR_MAX) ? mdl_err + 1 : mdl_err;
    endcase
  endtask

  task automatic push_word(input logic [33:0] w, input bit modeled);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
    if (modeled) model_word(w);
  endtask

  task automatic tick();
    logic [64:0] out;
    bit pop_now;
    @(negedge r_clk);
    out = {txn_we, txn_addr, txn_wdata};
    if (prev_hold && !r_rst) begin
      check("hold_valid", {64'd0, txn_valid}, 65'd1);
      check("hold_data", out, prev_out);
    end
    if (txn_valid && txn_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_txn: observed %0h expected none", out);
      end else begin
        check("txn", out, exp_q.pop_front());
      end
    end
    if (txn_valid) valid_cycles++;
    if (txn_valid && !last_valid) first_valid_cyc = cyc;
    last_valid = txn_valid;
    prev_hold  = txn_valid && !txn_ready;
    prev_out   = out;
    pop_now = fifo_r_en && !fifo_empty;
    if (pop_now) begin
      pop_cyc = cyc;
      pops++;
    end
    @(posedge r_clk);
    cyc++;
    #1;
    if (pop_now) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic check_err(input string tag);
`ifdef MEM_TXN_ASSEMBLER_ERR_CNT_EN
    check(tag, {63'd0, err_count}, 65'(mdl_err));
`else
    check(tag, {63'd0, err_count}, 65'd0);
`endif
  endtask

  task automatic do_reset();
    r_rst = 1'b1;
    tick();
    tick();
    check("rst_r_en", {64'd0, fifo_r_en}, 65'd0);
    check("rst_valid", {64'd0, txn_valid}, 65'd0);
    check("rst_out", {txn_we, txn_addr, txn_wdata}, 65'd0);
    check("rst_err", {63'd0, err_count}, 65'd0);
    r_rst = 1'b0;
    exp_q.delete();
    mdl_pend  = 0;
    mdl_err   = 0;
    prev_hold = 0;
  endtask

  task automatic drain(input string tag);
    int budget = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && budget < 300) begin
      tick();
      budget++;
    end
    check({tag, "_drain"}, 65'(budget < 300), 65'd1);
    repeat (4) tick();
    check_err({tag, "_err"});
  endtask

  initial begin
    r_rst = 1'b1;
    fifo_empty = 1'b1;
    fifo_data = '0;
    txn_ready = 1'b0;
    mdl_err = 0; mdl_pend = 0; mdl_addr = 0;
    prev_hold = 0; last_valid = 0; prev_out = '0;
    pop_cyc = 0; first_valid_cyc = -1; valid_cycles = 0; pops = 0;
    do_reset();

    // Single read: latency and one-cycle pulse.
    txn_ready = 1'b1;
    valid_cycles = 0;
    first_valid_cyc = -1;
    push_word({2'b01, 32'h0000_1000}, 1);
    repeat (6) tick();
    check("rd_latency", 65'(first_valid_cyc - pop_cyc), 65'd2);
    check("rd_pulse", 65'(valid_cycles), 65'd1);
    check("rd_done", 65'(exp_q.size()), 65'd0);

    // Write pair.
    push_word({2'b10, 32'h0000_2000}, 1);
    push_word({2'b11, 32'hDEAD_BEEF}, 1);
    drain("wr");

    // Backpressure with four reads.
    txn_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 4; i++) push_word({2'b01, 32'h3000 + 32'(i * 4)}, 1);
    repeat (10) tick();
    check("bp_pops", 65'(pops), 65'd3);
    check("bp_valid", {64'd0, txn_valid}, 65'd1);
    txn_ready = 1'b1;
    drain("bp");

    // Protocol errors, then saturation with stray data.
    do_reset();
    txn_ready = 1'b1;
    push_word({2'b11, 32'h1111_1111}, 1);
    push_word({2'b00, 32'h2222_2222}, 1);
    push_word({2'b10, 32'h0000_0010}, 1);
    push_word({2'b01, 32'h0000_0020}, 1);
    drain("errs");
    for (int i = 0; i < 5; i++) push_word({2'b11, 32'(i)}, 1);
    drain("sat");

    // Reset between write address and data.
    do_reset();
    txn_ready = 1'b1;
    push_word({2'b10, 32'h0000_4000}, 1);
    repeat (4) tick();
    valid_cycles = 0;
    do_reset();
    push_word({2'b11, 32'h5555_5555}, 1);
    drain("rst_wr");
    check("rst_wr_novalid", 65'(valid_cycles), 65'd0);

    // Reset while a write is waiting for acceptance.
    txn_ready = 1'b0;
    push_word({2'b10, 32'h0000_6000}, 1);
    push_word({2'b11, 32'h6666_6666}, 1);
    repeat (5) tick();
    check("hold_before_rst", {64'd0, txn_valid}, 65'd1);
    do_reset();
    txn_ready = 1'b1;
    drain("rst_out");

    // Reset in the cycle a popped word returns: that word is lost.
    push_word({2'b01, 32'h0000_7000}, 0);
    tick();
    push_word({2'b01, 32'h0000_7004}, 0);
    do_reset();
    model_word({2'b01, 32'h0000_7004});
    drain("rst_flight");

    // Randomized traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 40) begin
        int r;
        logic [1:0] tg;
        r = $urandom_range(0, 99);
        tg = (r < 35) ? 2'b01 : (r < 65) ? 2'b10 : (r < 95) ? 2'b11 : 2'b00;
        push_word({tg, 32'($urandom)}, 1);
      end
      txn_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    txn_ready = 1'b1;
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
